psum_writeback: RTL and testbench

- Downstream neighbour of the corelet output path: drains finished partial-sum vectors from the OFIFO and writes them into the psum SRAM (PMEM), one full column vector per write.
- Runs one transfer of num_vec vectors per start pulse, at consecutive addresses beginning at base_addr.
- Optionally applies per-lane ReLU on the way out.
- Removes the need for the testbench to hand-sequence the OFIFO_RD, CEN_PMEM, WEN_PMEM and A_PMEM instruction bits.

---
 rtl/psum_writeback.sv | 122 ++++++++++++
 tb/tb_psum_writeback.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback.sv
// psum_writeback: drains partial-sum vectors from the OFIFO into PMEM,
// one full column vector per write, with optional per-lane ReLU.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_vec,
  input  logic                     relu,
  input  logic                     ofifo_valid,
  input  logic [psum_bw*col-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     pmem_cen,
  output logic                     pmem_wen,
  output logic [addr_bw-1:0]       pmem_addr,
  output logic [psum_bw*col-1:0]   pmem_din,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [addr_bw-1:0]     base_q;
  logic [addr_bw-1:0]     num_q;
  logic [addr_bw-1:0]     count_q;
  logic                   relu_q;
  logic                   last_rd;
  logic [psum_bw*col-1:0] relu_data;

  // a lane is negative exactly when its sign bit is set
  always_comb begin
    relu_data = ofifo_data;
    for (int i = 0; i < col; i++) begin
      if (relu_q && ofifo_data[psum_bw*(i+1)-1]) begin
        relu_data[psum_bw*i +: psum_bw] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ofifo_rd = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    last_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        ofifo_rd = ofifo_valid && (count_q < num_q);
        last_rd  = ofifo_rd && (count_q == num_q - 1'b1);
        if (last_rd) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // write strobes follow the read by one cycle; addr/data hold on stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      num_q     <= '0;
      count_q   <= '0;
      relu_q    <= 1'b0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      pmem_din  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        base_q  <= base_addr;
        num_q   <= num_vec;
        relu_q  <= relu;
        count_q <= '0;
      end
      pmem_cen <= ~ofifo_rd;
      pmem_wen <= ~ofifo_rd;
      if (ofifo_rd) begin
        pmem_din  <= relu_data;
        pmem_addr <= base_q + count_q;
        count_q   <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: directed bench with an OFIFO model and a
// negedge monitor logging reads, writes and done pulses by cycle.
module tb_psum_writeback;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 11;
  localparam int DW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          relu = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_vec = '0;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_data;
  logic          ofifo_rd;
  logic          pmem_cen;
  logic          pmem_wen;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] pmem_din;
  logic          busy;
  logic          done;

  psum_writeback #(.col(COL), .psum_bw(BW), .addr_bw(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_vec    (num_vec),
    .relu       (relu),
    .ofifo_valid(ofifo_valid),
    .ofifo_data (ofifo_data),
    .ofifo_rd   (ofifo_rd),
    .pmem_cen   (pmem_cen),
    .pmem_wen   (pmem_wen),
    .pmem_addr  (pmem_addr),
    .pmem_din   (pmem_din),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;

  assign ofifo_valid = (wr_ptr != rd_ptr) && !hold;
  assign ofifo_data  = fifo_mem[rd_ptr % 16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ofifo_rd) rd_ptr <= rd_ptr + 1;
  end

  int            rd_cyc [$];
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            done_cyc [$];
  int            bad_ev = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ofifo_rd) begin
        rd_cyc.push_back(cyc);
        if (!ofifo_valid) bad_ev++;
      end
      if (!pmem_cen) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(pmem_addr);
        wr_data.push_back(pmem_din);
      end
      if (pmem_cen != pmem_wen) bad_ev++;
      if (done) begin
        done_cyc.push_back(cyc);
        if (busy) bad_ev++;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_ptr % 16] = v;
    wr_ptr++;
  endtask

  int c0, r0, w0, d0;

  task automatic mark();
    r0 = rd_cyc.size();
    w0 = wr_cyc.size();
    d0 = done_cyc.size();
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] n,
                          input logic r);
    @(negedge clk);
    base_addr = b;
    num_vec   = n;
    relu      = r;
    start     = 1'b1;
    c0        = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cyc.size() == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("done_timeout", 128'(done_cyc.size() > d0), 128'(1));
  endtask

  logic [DW-1:0] v_in;
  logic [DW-1:0] v_relu;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd", 128'(ofifo_rd), 128'(0));
    check("rst_cen", 128'(pmem_cen), 128'(1));
    check("rst_wen", 128'(pmem_wen), 128'(1));
    check("rst_addr", 128'(pmem_addr), 128'(0));
    check("rst_din", pmem_din, 128'(0));
    check("rst_busy", 128'({busy, done}), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic transfer
    for (int k = 1; k <= 4; k++) push(fill(16'(k)));
    mark();
    run_xfer(11'h010, 11'd4, 1'b0);
    check("t1_busy", 128'(busy), 128'(1));
    wait_done(50);
    check("t1_nrd", 128'(rd_cyc.size() - r0), 128'(4));
    check("t1_nwr", 128'(wr_cyc.size() - w0), 128'(4));
    for (int k = 0; k < 4; k++) begin
      check("t1_rdcyc", 128'(rd_cyc[r0+k] - c0), 128'(k + 1));
      check("t1_wrcyc", 128'(wr_cyc[w0+k] - c0), 128'(k + 2));
      check("t1_addr", 128'(wr_addr[w0+k]), 128'(11'h010 + k));
      check("t1_data", wr_data[w0+k], fill(16'(k + 1)));
    end
    check("t1_done", 128'(done_cyc[d0] - c0), 128'(6));
    start = 1'b1;
    num_vec = 11'd2;
    @(posedge clk);
    #1 start = 1'b0;
    check("t1_start_in_done", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);

    // 2: stall of five cycles after the first vector
    for (int k = 0; k < 3; k++) push(fill(16'h0A0 + 16'(k)));
    mark();
    run_xfer(11'h020, 11'd3, 1'b0);
    @(posedge clk);
    #1 hold = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(50);
    check("t2_nrd", 128'(rd_cyc.size() - r0), 128'(3));
    check("t2_nwr", 128'(wr_cyc.size() - w0), 128'(3));
    check("t2_rd1", 128'(rd_cyc[r0+1] - c0), 128'(7));
    check("t2_wr1", 128'(wr_cyc[w0+1] - c0), 128'(8));
    for (int k = 0; k < 3; k++) begin
      check("t2_addr", 128'(wr_addr[w0+k]), 128'(11'h020 + k));
      check("t2_data", wr_data[w0+k], fill(16'h0A0 + 16'(k)));
    end
    check("t2_done", 128'(done_cyc[d0] - c0), 128'(10));
    repeat (5) @(negedge clk);
    check("t2_one_done", 128'(done_cyc.size() - d0), 128'(1));

    // 3: ReLU on and off
    v_in   = {16'hFFFE, 16'h0001, 16'hFED4, 16'h0005,
              16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    v_relu = {16'h0000, 16'h0001, 16'h0000, 16'h0005,
              16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    push(v_in);
    mark();
    run_xfer(11'h030, 11'd1, 1'b1);
    wait_done(30);
    check("t3_relu", wr_data[w0], v_relu);
    push(v_in);
    mark();
    run_xfer(11'h031, 11'd1, 1'b0);
    wait_done(30);
    check("t3_norelu", wr_data[w0], v_in);
    check("t3_addr", 128'(wr_addr[w0]), 128'(11'h031));

    // 4: address wrap, then zero length
    for (int k = 0; k < 4; k++) push(fill(16'h0B0 + 16'(k)));
    mark();
    run_xfer(11'h7FE, 11'd4, 1'b0);
    wait_done(50);
    check("t4_a0", 128'(wr_addr[w0]), 128'(11'h7FE));
    check("t4_a1", 128'(wr_addr[w0+1]), 128'(11'h7FF));
    check("t4_a2", 128'(wr_addr[w0+2]), 128'(11'h000));
    check("t4_a3", 128'(wr_addr[w0+3]), 128'(11'h001));
    check("t4_d3", wr_data[w0+3], fill(16'h0B3));
    push(fill(16'h0DEA));
    mark();
    run_xfer(11'h040, 11'd0, 1'b0);
    wait_done(20);
    check("t4_zdone", 128'(done_cyc[d0] - c0), 128'(1));
    check("t4_znrd", 128'(rd_cyc.size() - r0), 128'(0));
    check("t4_znwr", 128'(wr_cyc.size() - w0), 128'(0));
    @(negedge clk);
    wr_ptr = rd_ptr;

    // 5: async reset mid-transfer, then fresh run with ignored start
    for (int k = 0; k < 6; k++) push(fill(16'h0C0 + 16'(k)));
    mark();
    run_xfer(11'h050, 11'd6, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_nwr", 128'(wr_cyc.size() - w0), 128'(2));
    check("t5_rd", 128'(ofifo_rd), 128'(0));
    check("t5_cen", 128'({pmem_cen, pmem_wen}), 128'(3));
    check("t5_addr", 128'(pmem_addr), 128'(0));
    check("t5_din", pmem_din, 128'(0));
    check("t5_busy", 128'({busy, done}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_nodone", 128'(done_cyc.size() - d0), 128'(0));
    wr_ptr = rd_ptr;
    for (int k = 0; k < 6; k++) push(fill(16'h0E0 + 16'(k)));
    mark();
    run_xfer(11'h100, 11'd6, 1'b0);
    @(posedge clk);
    #1;
    base_addr = 11'h555;
    num_vec   = 11'd1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(50);
    check("t5_nwr2", 128'(wr_cyc.size() - w0), 128'(6));
    for (int k = 0; k < 6; k++) begin
      check("t5_addr2", 128'(wr_addr[w0+k]), 128'(11'h100 + k));
      check("t5_data2", wr_data[w0+k], fill(16'h0E0 + 16'(k)));
    end
    check("t5_done2", 128'(done_cyc[d0] - c0), 128'(8));
    repeat (4) @(negedge clk);
    check("protocol", 128'(bad_ev), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
